// File: rtl/des_iter_core_if.sv
// Block handshake bundle for des_iter_core: message/key/mode in, result out.
// Latency: none, this is wiring only.
// Backpressure: valid/ready on both sides; in_ready is driven by the core.
interface des_iter_core_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:64] in_message;
  logic [1:64] in_key;
  logic        in_decrypt;
  logic        out_valid;
  logic        out_ready;
  logic [1:64] out_message;

  modport master (
    output in_valid, in_message, in_key, in_decrypt, out_ready,
    input  in_ready, out_valid, out_message
  );

  modport slave (
    input  in_valid, in_message, in_key, in_decrypt, out_ready,
    output in_ready, out_valid, out_message
  );
endinterface

// File: rtl/des_iter_core.sv
// Iterative DES encrypt/decrypt core that runs ROUNDS_PER_CYCLE Feistel rounds per clock.
// Latency: 16/ROUNDS_PER_CYCLE + 1 cycles from the accept cycle to the first out_valid cycle.
// Backpressure: the result is held in DONE until out_ready; in_ready is low during ROUND and during a stalled DONE.
module des_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input logic clk,
  input logic rst,
  des_iter_core_if.slave bus
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
        ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rounds
    $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // Table entry j is the source bit (FIPS numbering) of output bit j+1.
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                               16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  // Each S-box is 64 nibbles, entry (row*16 + col) counted from the most significant nibble.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};
  // Bit i set: round i+1 shifts the key halves by one place instead of two.
  localparam logic [15:0] SHIFT1 = 16'h8103;

  typedef struct packed {
    logic [1:32] l;
    logic [1:32] r;
    logic [1:28] c;
    logic [1:28] d;
  } blk_t;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  function automatic logic [1:64] perm_ip(input logic [1:64] v);
    logic [1:64] o;
    for (int j = 0; j < 64; j++) o[j+1] = v[IP_T[j]];
    return o;
  endfunction

  function automatic logic [1:64] perm_fp(input logic [1:64] v);
    logic [1:64] o;
    for (int j = 0; j < 64; j++) o[j+1] = v[FP_T[j]];
    return o;
  endfunction

  function automatic logic [1:56] perm_pc1(input logic [1:64] v);
    logic [1:56] o;
    for (int j = 0; j < 56; j++) o[j+1] = v[PC1_T[j]];
    return o;
  endfunction

  function automatic logic [1:48] perm_pc2(input logic [1:56] v);
    logic [1:48] o;
    for (int j = 0; j < 48; j++) o[j+1] = v[PC2_T[j]];
    return o;
  endfunction

  function automatic logic [1:28] rotl(input logic [1:28] v, input logic one);
    return one ? {v[2:28], v[1]} : {v[3:28], v[1:2]};
  endfunction

  function automatic logic [1:28] rotr(input logic [1:28] v, input logic one);
    return one ? {v[28], v[1:27]} : {v[27:28], v[1:26]};
  endfunction

  function automatic logic [1:32] feistel(input logic [1:32] r, input logic [1:48] k);
    logic [1:48] x;
    logic [1:32] s;
    logic [1:32] o;
    logic [5:0]  b;
    for (int j = 0; j < 48; j++) x[j+1] = r[E_T[j]];
    x = x ^ k;
    for (int i = 0; i < 8; i++) begin
      b = x[6*i+1 +: 6];
      s[4*i+1 +: 4] = SBOX[i][255 - 4*int'({b[5], b[0], b[4:1]}) -: 4];
    end
    for (int j = 0; j < 32; j++) o[j+1] = s[P_T[j]];
    return o;
  endfunction

  // Encrypt rotates left before the round; decrypt starts at K16 and rotates right after it.
  function automatic blk_t des_round(input blk_t s, input logic [3:0] idx, input logic dec);
    blk_t o;
    logic [1:28] c;
    logic [1:28] d;
    c = s.c;
    d = s.d;
    if (!dec) begin
      c = rotl(c, SHIFT1[idx]);
      d = rotl(d, SHIFT1[idx]);
    end
    o.l = s.r;
    o.r = s.l ^ feistel(s.r, perm_pc2({c, d}));
    if (dec) begin
      c = rotr(c, SHIFT1[4'd15 - idx]);
      d = rotr(d, SHIFT1[4'd15 - idx]);
    end
    o.c = c;
    o.d = d;
    return o;
  endfunction

  state_t      state;
  state_t      state_nxt;
  blk_t        blk;
  blk_t        nxt;
  logic        mode_dec;
  logic [3:0]  rnd;
  logic        valid_reg;
  logic [1:64] result;
  logic        accept;
  logic        last;

  assign bus.in_ready    = (state == IDLE) || (state == DONE && bus.out_ready);
  assign bus.out_valid   = valid_reg;
  assign bus.out_message = result;
  assign accept          = bus.in_valid && bus.in_ready;
  assign last            = ({1'b0, rnd} + 5'(ROUNDS_PER_CYCLE)) == 5'd16;

  // Chain this cycle's group of rounds starting at round index rnd.
  always_comb begin
    nxt = blk;
    for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
      nxt = des_round(nxt, rnd + 4'(k), mode_dec);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: a release from DONE may coincide with the next accept.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ROUND;
      ROUND:   if (last) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = accept ? ROUND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch on accept, iterate in ROUND, publish and hold the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk       <= '0;
      mode_dec  <= 1'b0;
      rnd       <= 4'd0;
      valid_reg <= 1'b0;
      result    <= '0;
    end else begin
      if (accept) begin
        blk      <= {perm_ip(bus.in_message), perm_pc1(bus.in_key)};
        mode_dec <= bus.in_decrypt;
        rnd      <= 4'd0;
      end else if (state == ROUND) begin
        blk <= nxt;
        rnd <= rnd + 4'(ROUNDS_PER_CYCLE);
      end
      if (state == ROUND && last) begin
        valid_reg <= 1'b1;
        result    <= perm_fp({nxt.r, nxt.l});
      end else if (state == DONE && bus.out_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_des_iter_core.sv
// Self-checking bench for des_iter_core: known-answer vectors, latency per round count, backpressure, reset abort.
// Latency: checked as cycles from the accept cycle to the first out_valid cycle.
// Backpressure: exercised by holding out_ready low in DONE and by a continuous back-to-back stream.
module tb_des_iter_core;

  localparam logic [63:0] K_FIPS = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT     = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT     = 64'h85E813540F0AB405;
  localparam logic [63:0] Z_CT   = 64'h8CA64DE9C1B123A7;
  localparam int AUX_LAT [4] = '{9, 5, 3, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [63:0] exp_q [$];

  // Main core, R = 1.
  des_iter_core_if if_m ();
  des_iter_core #(.ROUNDS_PER_CYCLE(1)) dut (.clk(clk), .rst(rst), .bus(if_m));

  // Auxiliary cores R = 2, 4, 8, 16 sharing one stimulus.
  logic        a_in_valid = 1'b0;
  logic        a_in_decrypt = 1'b0;
  logic        a_out_ready = 1'b0;
  logic [63:0] a_in_message = '0;
  logic [63:0] a_in_key = '0;
  logic        a_out_valid [4];
  logic        a_in_ready [4];
  logic [63:0] a_out_msg [4];
  int          aux_lat [4];
  logic [63:0] aux_msg [4];

  des_iter_core_if if_a [4] ();
  for (genvar g = 0; g < 4; g++) begin : g_aux
    assign if_a[g].in_valid   = a_in_valid;
    assign if_a[g].in_message = a_in_message;
    assign if_a[g].in_key     = a_in_key;
    assign if_a[g].in_decrypt = a_in_decrypt;
    assign if_a[g].out_ready  = a_out_ready;
    assign a_out_valid[g]     = if_a[g].out_valid;
    assign a_in_ready[g]      = if_a[g].in_ready;
    assign a_out_msg[g]       = if_a[g].out_message;
    des_iter_core #(.ROUNDS_PER_CYCLE(2 << g)) dut_a (.clk(clk), .rst(rst), .bus(if_a[g]));
  end

  // Present a block on the main core and hold it until accepted; acc is the accept-cycle stamp.
  task automatic drive_accept(input logic [63:0] msg, input logic [63:0] key, input logic dec, output int acc);
    int n;
    if_m.in_message = msg;
    if_m.in_key     = key;
    if_m.in_decrypt = dec;
    if_m.in_valid   = 1'b1;
    #1;
    n = 0;
    while (!if_m.in_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    acc = (n < 50) ? cyc : -1000;
    @(negedge clk);
    if_m.in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; lat = -1 if it never comes.
  task automatic wait_out(input int acc, output int lat, output logic [63:0] msg);
    int n;
    n = 0;
    lat = -1;
    msg = '0;
    while (!if_m.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (if_m.out_valid) begin
      lat = cyc - acc;
      msg = if_m.out_message;
    end
  endtask

  task automatic drain();
    if_m.out_ready = 1'b1;
    @(negedge clk);
    if_m.out_ready = 1'b0;
  endtask

  // Run one block through all auxiliary cores, recording first-valid latency and result.
  task automatic aux_block(input logic [63:0] msg, input logic [63:0] key, input logic dec);
    int acc;
    for (int g = 0; g < 4; g++) begin
      aux_lat[g] = -1;
      aux_msg[g] = '0;
    end
    a_in_message = msg;
    a_in_key     = key;
    a_in_decrypt = dec;
    a_out_ready  = 1'b0;
    a_in_valid   = 1'b1;
    acc = cyc;
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      for (int g = 0; g < 4; g++) begin
        if (a_out_valid[g] && aux_lat[g] < 0) begin
          aux_lat[g] = cyc - acc;
          aux_msg[g] = a_out_msg[g];
        end
      end
      @(negedge clk);
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] rdy;
    if_m.in_valid = 1'b0; if_m.in_decrypt = 1'b0; if_m.out_ready = 1'b0;
    if_m.in_message = '0; if_m.in_key = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++;
    if (if_m.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", if_m.out_valid); else pass_cnt++;
    total_cnt++;
    if (if_m.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", if_m.in_ready); else pass_cnt++;
    total_cnt++;
    if (if_m.out_message !== 64'h0) $display("FAIL reset_out_message got %h want 0", if_m.out_message); else pass_cnt++;
    rdy = {a_in_ready[3], a_in_ready[2], a_in_ready[1], a_in_ready[0]};
    total_cnt++;
    if (rdy !== 4'hF) $display("FAIL reset_aux_in_ready got %b want 1111", rdy); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_fips_encrypt();
    int acc, lat;
    logic [63:0] got, expv;
    if_m.out_ready = 1'b0;
    exp_q.push_back(CT);
    drive_accept(PT, K_FIPS, 1'b0, acc);
    wait_out(acc, lat, got);
    expv = exp_q.pop_front();
    total_cnt++;
    if (got !== expv) $display("FAIL fips_enc_msg got %h want %h", got, expv); else pass_cnt++;
    total_cnt++;
    if (lat !== 17) $display("FAIL fips_enc_latency got %0d want 17", lat); else pass_cnt++;
    drain();
    total_cnt++;
    if (if_m.out_valid !== 1'b0) $display("FAIL fips_enc_release got %b want 0", if_m.out_valid); else pass_cnt++;
  endtask

  task automatic test_decrypt_inverse();
    int acc, lat;
    logic [63:0] got, expv;
    if_m.out_ready = 1'b0;
    exp_q.push_back(PT);
    drive_accept(CT, K_FIPS, 1'b1, acc);
    wait_out(acc, lat, got);
    expv = exp_q.pop_front();
    total_cnt++;
    if (got !== expv) $display("FAIL fips_dec_msg got %h want %h", got, expv); else pass_cnt++;
    total_cnt++;
    if (lat !== 17) $display("FAIL fips_dec_latency got %0d want 17", lat); else pass_cnt++;
    drain();
    aux_block(CT, K_FIPS, 1'b1);
    for (int g = 0; g < 4; g++) begin
      total_cnt++;
      if (aux_msg[g] !== PT) $display("FAIL aux_dec_msg[R=%0d] got %h want %h", 2 << g, aux_msg[g], PT); else pass_cnt++;
      total_cnt++;
      if (aux_lat[g] !== AUX_LAT[g]) $display("FAIL aux_dec_latency[R=%0d] got %0d want %0d", 2 << g, aux_lat[g], AUX_LAT[g]); else pass_cnt++;
    end
    aux_block(PT, K_FIPS, 1'b0);
    for (int g = 0; g < 4; g++) begin
      total_cnt++;
      if (aux_msg[g] !== CT) $display("FAIL aux_enc_msg[R=%0d] got %h want %h", 2 << g, aux_msg[g], CT); else pass_cnt++;
    end
  endtask

  task automatic test_zero_vector();
    int acc, lat;
    logic [63:0] got, expv;
    if_m.out_ready = 1'b0;
    exp_q.push_back(Z_CT);
    drive_accept(64'h0, 64'h0, 1'b0, acc);
    repeat (4) @(negedge clk);
    if_m.in_key = '1;
    if_m.in_message = '1;
    if_m.in_decrypt = 1'b1;
    wait_out(acc, lat, got);
    expv = exp_q.pop_front();
    total_cnt++;
    if (got !== expv) $display("FAIL zero_vec_msg got %h want %h", got, expv); else pass_cnt++;
    total_cnt++;
    if (lat !== 17) $display("FAIL zero_vec_latency got %0d want 17", lat); else pass_cnt++;
    drain();
  endtask

  task automatic test_backpressure();
    int acc, acc2, lat;
    logic [63:0] got, expv;
    logic [65:0] obs;
    if_m.out_ready = 1'b0;
    exp_q.push_back(CT);
    drive_accept(PT, K_FIPS, 1'b0, acc);
    wait_out(acc, lat, got);
    expv = exp_q.pop_front();
    total_cnt++;
    if (got !== expv) $display("FAIL bp_first_msg got %h want %h", got, expv); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      obs = {if_m.out_valid, if_m.in_ready, if_m.out_message};
      total_cnt++;
      if (obs !== {1'b1, 1'b0, expv}) $display("FAIL bp_hold[%0d] got valid/ready/msg %h want %h", i, obs, {1'b1, 1'b0, expv}); else pass_cnt++;
    end
    if_m.in_message = CT;
    if_m.in_key = K_FIPS;
    if_m.in_decrypt = 1'b1;
    if_m.in_valid = 1'b1;
    if_m.out_ready = 1'b1;
    exp_q.push_back(PT);
    #1;
    total_cnt++;
    if (if_m.in_ready !== 1'b1) $display("FAIL bp_release_in_ready got %b want 1", if_m.in_ready); else pass_cnt++;
    acc2 = cyc;
    @(negedge clk);
    if_m.in_valid = 1'b0;
    total_cnt++;
    if (if_m.out_valid !== 1'b0) $display("FAIL bp_release_out_valid got %b want 0", if_m.out_valid); else pass_cnt++;
    wait_out(acc2, lat, got);
    expv = exp_q.pop_front();
    total_cnt++;
    if (got !== expv) $display("FAIL bp_second_msg got %h want %h", got, expv); else pass_cnt++;
    total_cnt++;
    if (lat !== 17) $display("FAIL bp_second_latency got %0d want 17", lat); else pass_cnt++;
    @(negedge clk);
    if_m.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int sent, recv, last_cyc, n;
    logic [63:0] expv;
    sent = 0; recv = 0; last_cyc = -1; n = 0;
    if_m.out_ready = 1'b1;
    if_m.in_key = K_FIPS;
    while (recv < 6 && n < 300) begin
      #1;
      if (if_m.out_valid) begin
        expv = exp_q.pop_front();
        total_cnt++;
        if (if_m.out_message !== expv) $display("FAIL b2b_msg[%0d] got %h want %h", recv, if_m.out_message, expv); else pass_cnt++;
        if (recv > 0) begin
          total_cnt++;
          if (cyc - last_cyc !== 17) $display("FAIL b2b_interval[%0d] got %0d want 17", recv, cyc - last_cyc); else pass_cnt++;
        end
        last_cyc = cyc;
        recv++;
      end
      if (if_m.in_ready && sent < 6) begin
        if_m.in_valid   = 1'b1;
        if_m.in_decrypt = sent[0];
        if_m.in_message = sent[0] ? CT : PT;
        exp_q.push_back(sent[0] ? PT : CT);
        sent++;
      end else if (if_m.in_ready) begin
        if_m.in_valid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    if_m.in_valid = 1'b0;
    if_m.out_ready = 1'b0;
    total_cnt++;
    if (recv !== 6) $display("FAIL b2b_count got %0d want 6", recv); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_block();
    int acc, lat, seen;
    logic [63:0] got, expv;
    if_m.out_ready = 1'b0;
    drive_accept(PT, K_FIPS, 1'b0, acc);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++;
    if (if_m.out_valid !== 1'b0) $display("FAIL rst_mid_out_valid got %b want 0", if_m.out_valid); else pass_cnt++;
    total_cnt++;
    if (if_m.in_ready !== 1'b1) $display("FAIL rst_mid_in_ready got %b want 1", if_m.in_ready); else pass_cnt++;
    total_cnt++;
    if (if_m.out_message !== 64'h0) $display("FAIL rst_mid_out_message got %h want 0", if_m.out_message); else pass_cnt++;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (if_m.out_valid) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL rst_mid_aborted got %0d valid cycles want 0", seen); else pass_cnt++;
    exp_q.push_back(PT);
    drive_accept(CT, K_FIPS, 1'b1, acc);
    wait_out(acc, lat, got);
    expv = exp_q.pop_front();
    total_cnt++;
    if (got !== expv) $display("FAIL rst_mid_next_msg got %h want %h", got, expv); else pass_cnt++;
    total_cnt++;
    if (lat !== 17) $display("FAIL rst_mid_next_latency got %0d want 17", lat); else pass_cnt++;
    drain();
  endtask

  initial begin
    test_reset();
    test_fips_encrypt();
    test_decrypt_inverse();
    test_zero_vector();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_block();
    total_cnt++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_empty got %0d left want 0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
